wishbone_manager: RTL and testbench
===================================

# wishbone_manager

Bus-side engine that sits directly downstream of the CPU request unit. It accepts one read or write request at a time on a simple level-driven CPU interface (read_i, write_i, adr_i, cpu_dat_i, sel_i) and runs exactly one classic single-beat Wishbone B4 cycle on the memory bus. It reports progress back to the request unit through busy_o and returns read data on cpu_dat_o. It owns all bus timing, so the request unit never sees STB, CYC or ACK.

## Interface
Parameters:
- ADDR_W, 32, width of adr_i / wb_adr_o
- TIMEOUT_CYCLES, 255, ACK wait limit; used only with WB_MANAGER_TIMEOUT_EN

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- read_i  input  1  read request level from request unit
- write_i  input  1  write request level from request unit
- adr_i  input  ADDR_W  byte address
- cpu_dat_i  input  32  write data
- sel_i  input  4  byte lane select
- busy_o  output  1  transaction in flight
- cpu_dat_o  output  32  last read data
- bus_err  output  1  one-cycle pulse on timeout abort
- wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone control
- wb_adr_o  output  ADDR_W  Wishbone address
- wb_dat_o  output  32  Wishbone write data
- wb_sel_o  output  4  Wishbone select
- wb_dat_i  input  32  Wishbone read data
- wb_ack_i  input  1  Wishbone acknowledge

## Operation
- States: IDLE, BUS (cycle open, waiting for ACK). All outputs are registered.
- IDLE: on a clock edge with read_i or write_i high, capture adr_i, cpu_dat_i and sel_i into the wb_* registers.
  - wb_we_o = write_i. If both requests are high, the write wins.
  - Assert wb_cyc_o, wb_stb_o and busy_o, then go to BUS.
- BUS: hold all wb_* outputs stable. The CPU inputs are ignored while in BUS.
- BUS, on an edge with wb_ack_i high:
  - Deassert wb_cyc_o, wb_stb_o and busy_o; return to IDLE.
  - If the cycle was a read, load cpu_dat_o from wb_dat_i.
  - After a write, cpu_dat_o is unchanged.
- cpu_dat_o holds its value until the next completed read.
- wb_ack_i while in IDLE is ignored.
- Back-to-back: IDLE always lasts at least one cycle, so busy_o is low for at least one cycle between transactions. A request still held high in that IDLE cycle starts the next transaction.
- wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o keep their last values in IDLE. Only wb_cyc_o and wb_stb_o qualify them.

## Timing
- Reset (async, immediate), all outputs 0: busy_o, cpu_dat_o, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o. State goes to IDLE.
- Reset mid-transaction drops CYC/STB at once and abandons the cycle. No data is returned.
- Request sampled at edge N: CYC, STB and busy_o are high after edge N.
- ACK sampled at edge N+k (k≥1): busy_o is low and cpu_dat_o is valid after edge N+k.
- Minimum transaction is 2 cycles, reached when the slave ACKs combinationally in the first STB cycle.
- busy_o rises in the cycle after the request is seen. The request unit must tolerate that one-cycle lag and hold its request until busy_o rises.
- STB and CYC are always equal. There is no pipelined or burst mode.

## Configuration
- Macro WB_MANAGER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to BUS and increments each BUS cycle without ACK.
  - When the counter reaches TIMEOUT_CYCLES: drop CYC/STB and busy_o, return to IDLE, and pulse bus_err for one cycle.
  - On a read abort, cpu_dat_o is set to 32'hDEAD_BEEF.
  - If ACK arrives on the same edge as the limit, ACK wins: normal completion, no bus_err.
- Undefined: no counter; BUS waits indefinitely; bus_err is tied to 0.

## Test plan
- Read, zero-wait slave: read_i=1, adr_i=32'h0000_0010. The slave ACKs in the first STB cycle with 32'h1234_5678. Expected:
  - wb_we_o=0 and wb_adr_o=32'h10.
  - busy_o high for exactly 1 cycle.
  - cpu_dat_o=32'h1234_5678 afterwards.
- Write, 3 wait states: write_i=1, adr_i=32'h20, cpu_dat_i=32'hCAFE_F00D, sel_i=4'hF. Expected:
  - wb_we_o=1 and wb_dat_o=32'hCAFE_F00D held stable for 4 cycles.
  - busy_o high for 4 cycles.
  - cpu_dat_o unchanged.
- Held request: read_i held high across two ACKs. Expected: two bus cycles separated by exactly one IDLE cycle with CYC=0 and busy_o=0.
- Simultaneous requests and stray ACK:
  - read_i=write_i=1 → a write cycle is issued.
  - wb_ack_i pulsed while IDLE → no state change and no output change.
- Reset in BUS: assert rst low mid-wait → CYC, STB and busy_o go to 0 immediately. After release, a new read completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): read with no ACK ever. Expected:
  - Abort after 8 BUS cycles.
  - bus_err pulses for one cycle.
  - cpu_dat_o=32'hDEAD_BEEF.
  - Repeat with ACK on the 8th cycle → normal data and no bus_err.

Source files
------------

// File: rtl/wishbone_manager_if.sv
// Wishbone B4 classic bus between the manager and one memory slave.
// Latency: none, wires only.
// Backpressure: the slave stalls the manager by withholding wb_ack_i.
interface wishbone_manager_if #(
    parameter int ADDR_W = 32
);
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wishbone_manager.sv
// Runs one single-beat Wishbone classic cycle per CPU read/write request level.
// Latency: CYC/STB/busy_o rise one edge after the request; done on the ACK edge.
// Backpressure: busy_o holds the request unit off; optional WB_MANAGER_TIMEOUT_EN aborts a hung slave.
module wishbone_manager #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [31:0]       cpu_dat_i,
    input  logic [3:0]        sel_i,
    output logic              busy_o,
    output logic [31:0]       cpu_dat_o,
    output logic              bus_err,
    wishbone_manager_if.master wb
);

    // Counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              bus_q,   bus_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] adr_q,   adr_d;
    logic [31:0]       wdat_q,  wdat_d;
    logic [3:0]        sel_q,   sel_d;
    logic [31:0]       rdat_q,  rdat_d;

`ifdef WB_MANAGER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]       cnt_q,   cnt_d;
    logic              err_q,   err_d;
`endif

    // Next-state and next-output decode; everything defaults to hold.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
`ifdef WB_MANAGER_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // ACK seen here is stray and deliberately ignored.
                if (read_i || write_i) begin
                    state_d = BUS;
                    bus_d   = 1'b1;
                    we_d    = write_i;
                    adr_d   = adr_i;
                    wdat_d  = cpu_dat_i;
                    sel_d   = sel_i;
`ifdef WB_MANAGER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                if (wb.wb_ack_i) begin
                    state_d = IDLE;
                    bus_d   = 1'b0;
                    if (!we_q) begin
                        rdat_d = wb.wb_dat_i;
                    end
                end
`ifdef WB_MANAGER_TIMEOUT_EN
                // ACK on the limit edge takes the branch above and wins.
                else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    bus_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdat_d = 32'hDEAD_BEEF;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                bus_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset abandons any open cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bus_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
`ifdef WB_MANAGER_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
`ifdef WB_MANAGER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // CYC, STB and busy are one flop so they can never disagree.
    assign busy_o      = bus_q;
    assign wb.wb_cyc_o = bus_q;
    assign wb.wb_stb_o = bus_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = wdat_q;
    assign wb.wb_sel_o = sel_q;
    assign cpu_dat_o   = rdat_q;

`ifdef WB_MANAGER_TIMEOUT_EN
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_manager.sv
module tb_wishbone_manager;

    logic        clk;
    logic        rst;
    logic        read_i;
    logic        write_i;
    logic [31:0] adr_i;
    logic [31:0] cpu_dat_i;
    logic [3:0]  sel_i;
    logic        busy_o;
    logic [31:0] cpu_dat_o;
    logic        bus_err;

    int tests  = 0;
    int errors = 0;

    wishbone_manager_if #(.ADDR_W(32)) wb ();

    wishbone_manager #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .read_i   (read_i),
        .write_i  (write_i),
        .adr_i    (adr_i),
        .cpu_dat_i(cpu_dat_i),
        .sel_i    (sel_i),
        .busy_o   (busy_o),
        .cpu_dat_o(cpu_dat_o),
        .bus_err  (bus_err),
        .wb       (wb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
        tests++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_ctl: got cyc=%b stb=%b we=%b exp 000", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o); end
        tests++; if (wb.wb_adr_o !== 32'h0 || wb.wb_dat_o !== 32'h0 || wb.wb_sel_o !== 4'h0) begin errors++; $display("FAIL rst_bus: got adr=%h dat=%h sel=%h exp 0", wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o); end
        tests++; if (cpu_dat_o !== 32'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_cpu: got dat=%h err=%b exp 0", cpu_dat_o, bus_err); end
    endtask

    task automatic test_read_zero_wait();
        read_i = 1'b1; adr_i = 32'h10;
        tick();
        read_i = 1'b0;
        tests++; if (busy_o !== 1'b1 || wb.wb_cyc_o !== 1'b1 || wb.wb_stb_o !== 1'b1) begin errors++; $display("FAIL rd_start: got busy=%b cyc=%b stb=%b exp 111", busy_o, wb.wb_cyc_o, wb.wb_stb_o); end
        tests++; if (wb.wb_we_o !== 1'b0 || wb.wb_adr_o !== 32'h10) begin errors++; $display("FAIL rd_addr: got we=%b adr=%h exp we=0 adr=00000010", wb.wb_we_o, wb.wb_adr_o); end
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h1234_5678;
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || wb.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rd_done: got busy=%b cyc=%b exp 00", busy_o, wb.wb_cyc_o); end
        tests++; if (cpu_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h exp 12345678", cpu_dat_o); end
    endtask

    task automatic test_write_wait3();
        int busy_cycles;
        busy_cycles = 0;
        write_i = 1'b1; adr_i = 32'h20; cpu_dat_i = 32'hCAFE_F00D; sel_i = 4'hF;
        tick();
        write_i = 1'b0; adr_i = 32'hFFFF_FFF0; cpu_dat_i = 32'h0BAD_0BAD; sel_i = 4'h1;
        for (int i = 0; i < 4; i++) begin
            if (busy_o === 1'b1) busy_cycles++;
            tests++; if (wb.wb_we_o !== 1'b1 || wb.wb_dat_o !== 32'hCAFE_F00D || wb.wb_adr_o !== 32'h20 || wb.wb_sel_o !== 4'hF) begin errors++; $display("FAIL wr_hold%0d: got we=%b dat=%h adr=%h sel=%h exp 1 cafef00d 00000020 f", i, wb.wb_we_o, wb.wb_dat_o, wb.wb_adr_o, wb.wb_sel_o); end
            if (i == 3) wb.wb_ack_i = 1'b1;
            tick();
        end
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_cycles != 4 || busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_len: got %0d cycles busy_now=%b exp 4 and 0", busy_cycles, busy_o); end
        tests++; if (cpu_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL wr_cpu_dat: got %h exp 12345678", cpu_dat_o); end
        tests++; if (wb.wb_dat_o !== 32'hCAFE_F00D || wb.wb_we_o !== 1'b1) begin errors++; $display("FAIL wr_idle_keep: got dat=%h we=%b exp cafef00d 1", wb.wb_dat_o, wb.wb_we_o); end
    endtask

    task automatic test_held_request();
        read_i = 1'b1; adr_i = 32'h30;
        tick();
        tests++; if (busy_o !== 1'b1) begin errors++; $display("FAIL held_first: got busy=%b exp 1", busy_o); end
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hAAAA_0001;
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || wb.wb_cyc_o !== 1'b0 || cpu_dat_o !== 32'hAAAA_0001) begin errors++; $display("FAIL held_gap: got busy=%b cyc=%b dat=%h exp 0 0 aaaa0001", busy_o, wb.wb_cyc_o, cpu_dat_o); end
        tick();
        read_i = 1'b0;
        tests++; if (busy_o !== 1'b1 || wb.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL held_second: got busy=%b cyc=%b exp 11", busy_o, wb.wb_cyc_o); end
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hBBBB_0002;
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || cpu_dat_o !== 32'hBBBB_0002) begin errors++; $display("FAIL held_done: got busy=%b dat=%h exp 0 bbbb0002", busy_o, cpu_dat_o); end
        tick();
        tests++; if (busy_o !== 1'b0) begin errors++; $display("FAIL held_no_third: got busy=%b exp 0", busy_o); end
    endtask

    task automatic test_simultaneous_and_stray();
        read_i = 1'b1; write_i = 1'b1; adr_i = 32'h40; cpu_dat_i = 32'h1111_2222; sel_i = 4'h3;
        tick();
        read_i = 1'b0; write_i = 1'b0;
        tests++; if (wb.wb_we_o !== 1'b1 || wb.wb_cyc_o !== 1'b1 || wb.wb_dat_o !== 32'h1111_2222) begin errors++; $display("FAIL both_write: got we=%b cyc=%b dat=%h exp 1 1 11112222", wb.wb_we_o, wb.wb_cyc_o, wb.wb_dat_o); end
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h7777_7777;
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || cpu_dat_o !== 32'hBBBB_0002) begin errors++; $display("FAIL both_done: got busy=%b dat=%h exp 0 bbbb0002", busy_o, cpu_dat_o); end
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hFFFF_FFFF;
        tick();
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0) begin errors++; $display("FAIL stray_ctl: got busy=%b cyc=%b stb=%b exp 000", busy_o, wb.wb_cyc_o, wb.wb_stb_o); end
        tests++; if (cpu_dat_o !== 32'hBBBB_0002 || wb.wb_adr_o !== 32'h40 || wb.wb_sel_o !== 4'h3 || wb.wb_we_o !== 1'b1) begin errors++; $display("FAIL stray_hold: got dat=%h adr=%h sel=%h we=%b exp bbbb0002 00000040 3 1", cpu_dat_o, wb.wb_adr_o, wb.wb_sel_o, wb.wb_we_o); end
    endtask

    task automatic test_reset_in_bus();
        read_i = 1'b1; adr_i = 32'h50;
        tick();
        read_i = 1'b0;
        tick();
        tests++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rib_wait: got busy=%b exp 1", busy_o); end
        #1 rst = 1'b0;
        #1;
        tests++; if (busy_o !== 1'b0 || wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0) begin errors++; $display("FAIL rib_drop: got busy=%b cyc=%b stb=%b exp 000", busy_o, wb.wb_cyc_o, wb.wb_stb_o); end
        tests++; if (cpu_dat_o !== 32'h0) begin errors++; $display("FAIL rib_dat: got %h exp 0", cpu_dat_o); end
        #1 rst = 1'b1;
        tick();
        read_i = 1'b1; adr_i = 32'h60;
        tick();
        read_i = 1'b0;
        tests++; if (busy_o !== 1'b1 || wb.wb_adr_o !== 32'h60) begin errors++; $display("FAIL rib_restart: got busy=%b adr=%h exp 1 00000060", busy_o, wb.wb_adr_o); end
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h5A5A_5A5A;
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || cpu_dat_o !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rib_read: got busy=%b dat=%h exp 0 5a5a5a5a", busy_o, cpu_dat_o); end
    endtask

`ifdef WB_MANAGER_TIMEOUT_EN
    task automatic test_timeout();
        read_i = 1'b1; adr_i = 32'h70;
        tick();
        read_i = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            tests++; if (busy_o !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got busy=%b err=%b exp 1 0", i, busy_o, bus_err); end
        end
        tick();
        tests++; if (busy_o !== 1'b0 || wb.wb_cyc_o !== 1'b0 || bus_err !== 1'b1) begin errors++; $display("FAIL to_abort: got busy=%b cyc=%b err=%b exp 0 0 1", busy_o, wb.wb_cyc_o, bus_err); end
        tests++; if (cpu_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_dat: got %h exp deadbeef", cpu_dat_o); end
        tick();
        tests++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got err=%b exp 0", bus_err); end
        read_i = 1'b1; adr_i = 32'h74;
        tick();
        read_i = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h0BAD_F00D;
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || bus_err !== 1'b0 || cpu_dat_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL to_ack_wins: got busy=%b err=%b dat=%h exp 0 0 0badf00d", busy_o, bus_err, cpu_dat_o); end
        tick();
        tests++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_ack_noerr: got err=%b exp 0", bus_err); end
    endtask
`else
    task automatic test_timeout();
        read_i = 1'b1; adr_i = 32'h70;
        tick();
        read_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        tests++; if (busy_o !== 1'b1 || wb.wb_cyc_o !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL nto_wait: got busy=%b cyc=%b err=%b exp 1 1 0", busy_o, wb.wb_cyc_o, bus_err); end
        wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h0BAD_F00D;
        tick();
        wb.wb_ack_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || bus_err !== 1'b0 || cpu_dat_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL nto_done: got busy=%b err=%b dat=%h exp 0 0 0badf00d", busy_o, bus_err, cpu_dat_o); end
    endtask
`endif

    // Safety net: the sequence is fixed-length, so this only fires on a broken run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0;
        adr_i = '0; cpu_dat_i = '0; sel_i = '0;
        wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0;
        #2;
        test_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        test_read_zero_wait();
        test_write_wait3();
        test_held_request();
        test_simultaneous_and_stray();
        test_reset_in_bus();
        tick();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
